// File: rtl/fas_peak_detector_if.sv
// FFT frame bus between an FFT source and the peak detector: one-cycle frame
// strobe with 16 complex bins forward, peak result and status back.
interface fas_peak_detector_if #(
    parameter int DATA_W = 16
);
    logic                             fft_valid;
    logic [15:0][2*DATA_W-1:0]        fft_d;
    logic                             done;
    logic [3:0]                       freq;
    logic [2*DATA_W:0]                mag_max;
    logic                             busy;
    logic                             overrun;

    modport master (
        output fft_valid, fft_d,
        input  done, freq, mag_max, busy, overrun
    );

    modport slave (
        input  fft_valid, fft_d,
        output done, freq, mag_max, busy, overrun
    );
endinterface

// File: rtl/fas_peak_detector.sv
// Captures a 16-bin complex frame, scans one bin per cycle for the largest re^2+im^2.
// Result 17 cycles after capture; frames arriving mid-scan are dropped and flagged.
module fas_peak_detector #(
    parameter int DATA_W  = 16,
    parameter bit SKIP_DC = 1'b0
) (
    input  logic                        clk,
    input  logic                        rst,
    fas_peak_detector_if.slave          bus
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                      state_q, state_d;
    logic [15:0][2*DATA_W-1:0]   frame_q, frame_d;
    logic [3:0]                  idx_q, idx_d;
    logic [3:0]                  best_idx_q, best_idx_d;
    logic [2*DATA_W:0]           best_mag_q, best_mag_d;
    logic                        have_best_q, have_best_d;
    logic [3:0]                  freq_q, freq_d;
    logic [2*DATA_W:0]           mag_max_q, mag_max_d;
    logic                        overrun_q, overrun_d;

    logic signed [2*DATA_W-1:0]  re_x, im_x;
    logic [2*DATA_W-1:0]         re_sq, im_sq;
    logic [2*DATA_W:0]           mag;
    logic                        upd;

    // Sign-extend to full product width so the square is exact, never wrapped.
    assign re_x  = {{DATA_W{frame_q[idx_q][2*DATA_W-1]}}, frame_q[idx_q][2*DATA_W-1:DATA_W]};
    assign im_x  = {{DATA_W{frame_q[idx_q][DATA_W-1]}}, frame_q[idx_q][DATA_W-1:0]};
    assign re_sq = re_x * re_x;
    assign im_sq = im_x * im_x;
    assign mag   = {1'b0, re_sq} + {1'b0, im_sq};
    assign upd   = (!SKIP_DC || (idx_q != 4'd0)) && (!have_best_q || (mag > best_mag_q));

    always_comb begin
        state_d     = state_q;
        frame_d     = frame_q;
        idx_d       = idx_q;
        best_idx_d  = best_idx_q;
        best_mag_d  = best_mag_q;
        have_best_d = have_best_q;
        freq_d      = freq_q;
        mag_max_d   = mag_max_q;
        overrun_d   = 1'b0;
        case (state_q)
            // DONE accepts a new frame so back-to-back frames run at one per 17 cycles.
            IDLE, DONE: begin
                state_d = IDLE;
                if (bus.fft_valid) begin
                    frame_d     = bus.fft_d;
                    idx_d       = 4'd0;
                    best_idx_d  = 4'd0;
                    best_mag_d  = '0;
                    have_best_d = 1'b0;
                    state_d     = CALC;
                end
            end
            CALC: begin
                overrun_d = bus.fft_valid;
                if (upd) begin
                    best_idx_d  = idx_q;
                    best_mag_d  = mag;
                    have_best_d = 1'b1;
                end
                idx_d = idx_q + 4'd1;
                if (idx_q == 4'd15) begin
                    freq_d    = best_idx_d;
                    mag_max_d = best_mag_d;
                    state_d   = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            frame_q     <= '0;
            idx_q       <= '0;
            best_idx_q  <= '0;
            best_mag_q  <= '0;
            have_best_q <= 1'b0;
            freq_q      <= '0;
            mag_max_q   <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
            best_idx_q  <= best_idx_d;
            best_mag_q  <= best_mag_d;
            have_best_q <= have_best_d;
            freq_q      <= freq_d;
            mag_max_q   <= mag_max_d;
            overrun_q   <= overrun_d;
        end
    end

    assign bus.done    = (state_q == DONE);
    assign bus.busy    = (state_q != IDLE);
    assign bus.freq    = freq_q;
    assign bus.mag_max = mag_max_q;
    assign bus.overrun = overrun_q;
endmodule
